// File: rtl/router_pkg.sv
// Shared router definitions: port count, pointer width, port indices and the
// arbiter state encoding used by every output-port arbiter.
package router_pkg;

    localparam int N_PORTS = 5;
    localparam int PTR_W   = 3;

    localparam logic [PTR_W-1:0] PORT_0 = 3'd0;
    localparam logic [PTR_W-1:0] PORT_1 = 3'd1;
    localparam logic [PTR_W-1:0] PORT_2 = 3'd2;
    localparam logic [PTR_W-1:0] PORT_3 = 3'd3;
    localparam logic [PTR_W-1:0] PORT_4 = 3'd4;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: returns the first requesting index found
// when scanning ptr, ptr+1, ... modulo N.
module rr_priority_pick
    import router_pkg::*;
#(
    parameter int N = router_pkg::N_PORTS,
    parameter int W = router_pkg::PTR_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);

    logic [W-1:0] cand_idx [N];
    logic [N-1:0] cand_req;

    // Candidate gi is the port gi positions after the pointer, wrapped.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [W:0] sum;
            assign sum          = {1'b0, ptr} + (W+1)'(gi);
            assign cand_idx[gi] = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                winner = cand_idx[k];
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/output_port_arbiter_rr.sv
// Round-robin wormhole arbiter for one output port: one-hot registered grant,
// locked until the tail flit leaves, with a sticky lock-timeout flag.
module output_port_arbiter_rr
    import router_pkg::*;
#(
    parameter int N_PORTS = router_pkg::N_PORTS,
    parameter int PTR_W   = router_pkg::PTR_W,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic               out_ready,
    input  logic               tail_done,
    output logic [N_PORTS-1:0] grant,
    output logic               grant_valid,
    output logic               lock_timeout
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t         state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [PTR_W-1:0]   winner_reg, winner_next;
    logic [N_PORTS-1:0] grant_reg, grant_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               timeout_reg, timeout_next;

    logic [PTR_W-1:0]   pick_winner;
    logic               pick_any;

    rr_priority_pick #(
        .N (N_PORTS),
        .W (PTR_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_reg),
        .winner  (pick_winner),
        .any_req (pick_any)
    );

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        winner_next  = winner_reg;
        grant_next   = grant_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            ARB_IDLE: begin
                grant_next = '0;
                cnt_next   = '0;
                if (pick_any && out_ready) begin
                    state_next  = ARB_LOCKED;
                    winner_next = pick_winner;
                    grant_next  = N_PORTS'(1) << pick_winner;
                end
            end
            ARB_LOCKED: begin
                // Counter saturates; the flag only reports, it never breaks the lock.
                if (TIMEOUT > 0) begin
                    if (cnt_reg != CNT_W'(TIMEOUT)) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                    if (cnt_next == CNT_W'(TIMEOUT)) begin
                        timeout_next = 1'b1;
                    end
                end
                if (tail_done) begin
                    state_next = ARB_IDLE;
                    grant_next = '0;
                    cnt_next   = '0;
                    ptr_next   = (winner_reg == PTR_W'(N_PORTS - 1)) ? '0 : winner_reg + 1'b1;
                end
            end
            default: begin
                state_next = ARB_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ARB_IDLE;
            ptr_reg     <= '0;
            winner_reg  <= '0;
            grant_reg   <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            winner_reg  <= winner_next;
            grant_reg   <= grant_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign grant        = grant_reg;
    assign grant_valid  = |grant_reg;
    assign lock_timeout = timeout_reg;

endmodule

// File: tb/tb_output_port_arbiter_rr.sv
// Directed and random bench for output_port_arbiter_rr, checked against a
// packet-level model of the round-robin wormhole arbitration rules.
module tb_output_port_arbiter_rr;

    localparam int NP = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req;
    logic          out_ready;
    logic          tail_done;
    logic [NP-1:0] grant;
    logic          grant_valid;
    logic          lock_timeout;

    int n_checks = 0;
    int n_fails  = 0;

    // Packet-level model: who owns the port, where the search starts next,
    // how many locked cycles have elapsed and whether the timeout latched.
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_lcnt;
    bit m_to;

    output_port_arbiter_rr #(
        .N_PORTS (NP),
        .PTR_W   (3),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .out_ready    (out_ready),
        .tail_done    (tail_done),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_lcnt   = 0;
        m_to     = 1'b0;
    endtask

    task automatic model_edge();
        bit found;
        if (m_locked) begin
            if (m_lcnt < TO) m_lcnt++;
            if (m_lcnt >= TO) m_to = 1'b1;
            if (tail_done) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % NP;
                m_lcnt   = 0;
            end
        end else if (req != '0 && out_ready) begin
            found = 1'b0;
            for (int k = 0; k < NP; k++) begin
                if (!found && req[(m_ptr + k) % NP]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % NP;
                end
            end
            m_locked = 1'b1;
            m_lcnt   = 0;
        end
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic tick();
        logic [NP-1:0] exp_grant;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_grant = m_locked ? NP'(1 << m_owner) : '0;
        check("model_grant", 32'(grant), 32'(exp_grant));
        check("model_grant_valid", 32'(grant_valid), 32'(exp_grant != '0));
        check("model_lock_timeout", 32'(lock_timeout), 32'(m_to));
        check("onehot0_grant", 32'($onehot0(grant)), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        tail_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_grant_valid", 32'(grant_valid), 32'h0);
        check("reset_lock_timeout", 32'(lock_timeout), 32'h0);
        rst = 1'b0;
        tick();

        // Pointer 0 picks port 2; after release ptr=3 so port 4 wins.
        req = 5'b10100; out_ready = 1'b1;
        tick();
        check("first_grant", 32'(grant), 32'h04);
        check("first_grant_valid", 32'(grant_valid), 32'h1);
        tail_done = 1'b1;
        tick();
        check("release_bubble", 32'(grant), 32'h0);
        tail_done = 1'b0;
        tick();
        check("ptr_skip_grant", 32'(grant), 32'h10);
        tail_done = 1'b1; req = '0;
        tick();
        check("wrap_release", 32'(grant), 32'h0);
        tail_done = 1'b0;

        // All ports requesting: strict rotation with one bubble per packet.
        req = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            logic [NP-1:0] exp_rot;
            exp_rot = NP'(1 << (i % NP));
            tick();
            check("rotation_grant", 32'(grant), 32'(exp_rot));
            tick();
            tail_done = 1'b1;
            tick();
            check("rotation_bubble", 32'(grant), 32'h0);
            tail_done = 1'b0;
        end

        // out_ready gates new grants but never revokes a held one.
        req = 5'b00010; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("not_ready_idle", 32'(grant), 32'h0);
        end
        out_ready = 1'b1;
        tick();
        check("ready_grant", 32'(grant), 32'h02);
        out_ready = 1'b0; req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_hold", 32'(grant), 32'h02);
        end
        tail_done = 1'b1;
        tick();
        check("hold_release", 32'(grant), 32'h0);
        tail_done = 1'b0;

        // Timeout: flag rises after TO full locked cycles, grant stays held.
        req = 5'b00001; out_ready = 1'b1;
        tick();
        check("timeout_grant", 32'(grant), 32'h01);
        check("timeout_c0", 32'(lock_timeout), 32'h0);
        req = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            check("timeout_flag", 32'(lock_timeout), 32'(c >= TO));
            check("timeout_hold", 32'(grant), 32'h01);
        end
        tail_done = 1'b1;
        tick();
        check("timeout_release", 32'(grant), 32'h0);
        check("timeout_sticky", 32'(lock_timeout), 32'h1);
        tail_done = 1'b0;

        // Async reset mid-packet: grant drops immediately, ptr returns to 0.
        req = 5'b01000; out_ready = 1'b1;
        tick();
        check("pre_reset_grant", 32'(grant), 32'h08);
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_reset_grant", 32'(grant), 32'h0);
        check("async_reset_valid", 32'(grant_valid), 32'h0);
        check("async_reset_timeout", 32'(lock_timeout), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 5'b01001;
        tick();
        check("post_reset_grant", 32'(grant), 32'h01);
        tail_done = 1'b1;
        tick();
        tail_done = 1'b0;

        // Random traffic; the model comparison covers lock stability and one-hot.
        for (int i = 0; i < 10000; i++) begin
            req       = NP'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            tail_done = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/output_port_arbiter_rr.md
Name: output_port_arbiter_rr

Overview:
Round-robin wormhole arbiter for one router output port. It collects requests from the 5 input ports and issues a registered one-hot grant. The grant stays locked for the whole packet until the tail flit leaves. Its grant bits drive the downstream per-output selector: grant[i] feeds g<out><i>, so exactly one or zero grant bits are ever high.

Parameters:
N_PORTS, 5, number of requesting input ports (grant/request width)
PTR_W, 3, width of round-robin pointer (ceil(log2(N_PORTS)))
TIMEOUT, 64, locked cycles without tail before lock_timeout asserts; 0 disables

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req  input  N_PORTS  per-input request for this output port (level, held while head flit waits)
out_ready  input  1  downstream can accept a flit (credit available); gates new grants only
tail_done  input  1  one-cycle pulse: tail flit of granted packet transferred this cycle
grant  output  N_PORTS  registered one-hot grant, 0 when idle
grant_valid  output  1  OR of grant
lock_timeout  output  1  sticky: lock exceeded TIMEOUT cycles; cleared only by rst

Behaviour:
- Reset (async, immediate): grant=0, grant_valid=0, lock_timeout=0, ptr=0, state=IDLE, lock counter=0.
- State IDLE:
  - If |req and out_ready, pick a winner and go to LOCKED.
  - Winner = first set req bit searching ptr, ptr+1, ..., wrapping mod N_PORTS.
  - grant is registered, so the winner is visible the cycle after req/out_ready are sampled (latency 1).
  - If req=0 or out_ready=0: stay IDLE, grant=0.
- State LOCKED:
  - grant holds its value every cycle regardless of req or out_ready changes; out_ready does not revoke a grant.
  - Deasserting the granted req without tail_done is ignored; the grant holds (no abort).
  - tail_done=1: next cycle grant=0, state=IDLE, ptr=(winner+1) mod N_PORTS, lock counter=0.
  - There is exactly one idle bubble cycle between packets. No same-cycle re-arbitration.
- tail_done in IDLE: ignored, no state change.
- Lock counter:
  - Increments each LOCKED cycle and saturates at TIMEOUT.
  - When it reaches TIMEOUT (TIMEOUT>0), lock_timeout goes to 1 and stays 1. The grant is not released.
- Pointer wrap: winner 4 → ptr 0.
- Winner width/encoding: internal winner index is PTR_W bits; grant = 1<<winner.
- Invariant: $onehot0(grant) at all times. grant_valid == |grant.
- Reset asserted mid-packet: grant drops asynchronously and ptr returns to 0. The in-flight packet is the system's responsibility.

Decomposition:
- Shared package router_pkg:
  - N_PORTS=5.
  - Port index constants PORT_0..PORT_4.
  - State enum {ARB_IDLE, ARB_LOCKED}.
  - PTR_W.
- One natural sub-module: rr_priority_pick. Purely combinational; inputs req and ptr, outputs winner index and any_req. Reused by all 5 output arbiters in the router.
- Top module holds the FSM, the pointer, the grant register and the timeout counter.

Test Plan:
- Reset, then req=5'b10100 with out_ready=1 → next cycle grant=5'b00100, grant_valid=1. Pulse tail_done → following cycle grant=0. Next cycle grant=5'b10000 (ptr=3 skips bit 2).
- req=5'b11111 held, tail_done pulsed 2 cycles after each grant → grant sequence 00001, 00010, 00100, 01000, 10000, 00001, with one zero cycle between each.
- req=5'b00010 with out_ready=0 for 5 cycles → grant=0 throughout. Raise out_ready → grant=5'b00010 one cycle later. Then drop out_ready and req while locked → grant stays 00010 until tail_done.
- TIMEOUT=16, grant locked with no tail_done → lock_timeout=0 through locked cycle 15, =1 from cycle 16 onward. Grant still held. tail_done → grant releases, lock_timeout stays 1.
- Locked on grant=5'b01000, assert rst mid-cycle → grant=0 immediately (async). After release with req=5'b01001 → grant=5'b00001 (ptr back to 0).
- Random req/out_ready/tail_done for 10k cycles → assertions $onehot0(grant) hold; no grant change while LOCKED except via tail_done or rst.
